asm_line_decoder: RTL
=====================

# asm_line_decoder

Text-to-machine-code loader for the 8-bit CPU; performs the inverse of the instruction-display path. Accepts an ASCII byte stream (one assembly statement per line, e.g. "ADD A B", "LD A 12", "JMP 40", "HALT") from a serial receiver through a valid/ready handshake. Encodes each statement into the CPU's 8-bit opcode plus an optional operand byte, and writes them to consecutive program-memory addresses. Sits between the UART/keyboard front end and the program RAM write port.

## Interface
- START_ADDR, 8'h00, first program-memory address written after reset
- CLK  in  1  system clock (50 MHz)
- reset_btn  in  1  synchronous, active-high reset
- rx_valid  in  1  rx_data holds a character
- rx_data  in  8  ASCII character
- rx_ready  out  1  character accepted on a cycle where rx_valid && rx_ready
- mem_we  out  1  program-memory write strobe, one cycle per byte
- mem_addr  out  8  write address (current address counter)
- mem_wdata  out  8  opcode or operand byte
- line_ok  out  1  one-cycle pulse: statement encoded and written
- line_err  out  1  one-cycle pulse: statement rejected, nothing written
- wrap  out  1  sticky; set when the address counter wraps 8'hFF->8'h00

## Operation
- **Character classes:**
  - Letters a–z are folded to A–Z.
  - Space (0x20) is a separator; runs of spaces count as one.
  - EOL is CR (0x0D) or LF (0x0A).
  - Digits are 0–9.
  - Anything else is an error.
- **Grammar:** MNEM [REG [REG]] [NUM] EOL.
  - MNEM is 1–4 letters.
  - REG is a single token "A" or "B".
  - NUM is 1–3 decimal digits, value 0–255.
- **Encoding:**
  - ALU ops take base + 0 for "A", +1 for "B", +2 for "A B", +3 for "B A".
  - ALU bases: ADD 8'h92, SUB 8'h96, MUL 8'h9A, DIV 8'h9E, SHL 8'hA2, SHR 8'hA6.
  - LD A = 8'h90 and LD B = 8'h91; both require NUM.
  - ST = 8'hC0 and JMP = 8'hC1; both require NUM and take no REG.
  - HALT = 8'hFF, with no REG and no NUM.
  - ALU ops forbid NUM.
- **Errors:**
  - Unknown mnemonic.
  - Mnemonic longer than 4 letters.
  - REG other than A/B, a third REG, or a repeated pair ("A A").
  - Wrong argument shape for the mnemonic.
  - NUM greater than 255 or with more than 3 digits.
  - Letter after NUM.
  - Illegal character.
  - On error: enter ERR, discard characters up to and including EOL, pulse line_err, write nothing, leave the address unchanged.
- **Empty lines:** EOL with no pending token (including LF after CR) is ignored, with no pulse.
- **State machine:**
  - States are MNEM, REG, NUM, ERR, EMIT_OP, EMIT_ARG.
  - MNEM collects letters.
  - REG/NUM collect arguments; NUM accumulates value = value*10 + digit in 10 bits.
  - EOL in a valid state goes to EMIT_OP.
  - EMIT_OP goes to EMIT_ARG if there is an operand, else back to MNEM.
  - EMIT_ARG goes to MNEM.
  - ERR returns to MNEM on EOL.
- **Address counter:**
  - Post-increments on every mem_we.
  - Wraps modulo 256 and sets wrap (cleared only by reset).

## Timing
- **Reset values:** rx_ready=1, mem_we=0, mem_addr=START_ADDR, mem_wdata=0, line_ok=0, line_err=0, wrap=0; parser in MNEM with buffers cleared.
- **Reset mid-line or mid-emit:** discards all partial state; no further writes.
- **Handshake:** at most one character per cycle. rx_ready is 0 during EMIT_OP and EMIT_ARG, and 1 in every other state.
- **EOL accepted at cycle N:**
  - N+1: mem_we=1 with opcode at addr a.
  - If there is an operand, N+2: mem_we=1 with operand at a+1.
  - line_ok pulses in the same cycle as the last write.
  - rx_ready returns to 1 the cycle after the last write.
- **Error path:** line_err pulses on cycle N+1 after the EOL that terminates ERR; rx_ready stays 1 throughout.
- mem_addr/mem_wdata are registered and valid whenever mem_we=1.

## Test plan
- Reset, then "ADD A B\r\n" -> one write 8'h94 @ 8'h00, line_ok once, mem_addr=8'h01, LF ignored.
- "ld b 200\n" then "jmp 7\n" -> writes 8'h91 @0, 8'hC8 @1, 8'hC1 @2, 8'h07 @3; rx_ready low exactly on write cycles.
- "ADD C\n", "LD A 256\n", "HALT 3\n", "ADDXY A\n" -> four line_err pulses, zero writes, address unchanged.
- "  SHR   B   A\n" -> 8'hA9 written; "HALT\n" -> 8'hFF.
- START_ADDR=8'hFE, "ST 5\n" -> 8'hC0 @FE, 8'h05 @FF, mem_addr=00, wrap=1; next line writes @00.
- rx_valid held high continuously with "SUB B\nDIV A\n" -> no characters lost across the emit stall; writes 8'h97 then 8'h9E; reset asserted mid-"MUL A" -> no writes, mem_addr=START_ADDR.

Source files
------------

// File: rtl/asm_line_decoder.sv
`default_nettype none
// ============================================================================
// Module   : asm_line_decoder
// Purpose  : Parses one ASCII assembly statement per line and writes the
//            encoded opcode (+ optional operand) to program memory.
// Revision : 1.0 - initial release
// ============================================================================
module asm_line_decoder #(
    parameter logic [7:0] START_ADDR = 8'h00
) (
    input  logic       CLK,
    input  logic       reset_btn,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       line_ok,
    output logic       line_err,
    output logic       wrap
);
    typedef enum logic [2:0] {
        S_MNEM, S_REG, S_NUM, S_ERR, S_EMIT_OP, S_EMIT_ARG
    } state_t;

    state_t      state, state_n;
    logic [31:0] mnem, mnem_n;
    logic [2:0]  mlen, mlen_n;
    logic [1:0]  nregs, nregs_n;
    logic        reg0, reg0_n;      // first register: 0 = A, 1 = B
    logic        in_tok, in_tok_n;  // previous character was a register letter
    logic [9:0]  val, val_n;
    logic [1:0]  ndig, ndig_n;
    logic        num_sep, num_sep_n;
    logic [7:0]  arg_q, arg_n;
    logic        has_arg, has_arg_n;
    logic [7:0]  addr;
    logic        we_n, ok_n, err_n;
    logic [7:0]  wdata_n;

    logic [7:0]  ch;
    logic        is_letter, is_digit, is_space, is_eol, is_b, accept;
    logic        alu, is_ld, is_sj, is_halt, has_num, num_ok;
    logic [7:0]  base, enc_op;
    logic        enc_ok, enc_has_arg;
    logic        finish, clear;

    assign ch        = (rx_data >= 8'h61 && rx_data <= 8'h7A) ? rx_data - 8'h20 : rx_data;
    assign is_letter = (ch >= 8'h41) && (ch <= 8'h5A);
    assign is_digit  = (ch >= 8'h30) && (ch <= 8'h39);
    assign is_space  = (ch == 8'h20);
    assign is_eol    = (ch == 8'h0D) || (ch == 8'h0A);
    assign is_b      = (ch == 8'h42);
    assign rx_ready  = (state != S_EMIT_OP) && (state != S_EMIT_ARG);
    assign accept    = rx_valid && rx_ready;
    assign mem_addr  = addr;
    assign has_num   = (state == S_NUM);
    assign num_ok    = (val <= 10'd255);

    // Statement encoder, evaluated against the collected tokens when EOL arrives.
    always_comb begin
        alu = 1'b0; is_ld = 1'b0; is_sj = 1'b0; is_halt = 1'b0;
        base = 8'h00; enc_ok = 1'b0; enc_op = 8'h00; enc_has_arg = 1'b0;
        case (mnem)
            {8'h00, "ADD"}:  begin alu = 1'b1; base = 8'h92; end
            {8'h00, "SUB"}:  begin alu = 1'b1; base = 8'h96; end
            {8'h00, "MUL"}:  begin alu = 1'b1; base = 8'h9A; end
            {8'h00, "DIV"}:  begin alu = 1'b1; base = 8'h9E; end
            {8'h00, "SHL"}:  begin alu = 1'b1; base = 8'hA2; end
            {8'h00, "SHR"}:  begin alu = 1'b1; base = 8'hA6; end
            {16'h0000, "LD"}: is_ld = 1'b1;
            {16'h0000, "ST"}: begin is_sj = 1'b1; base = 8'hC0; end
            {8'h00, "JMP"}:  begin is_sj = 1'b1; base = 8'hC1; end
            "HALT":          is_halt = 1'b1;
            default:         ;
        endcase
        if (alu) begin
            enc_ok = (nregs != 2'd0) && !has_num;
            enc_op = base + ((nregs == 2'd1) ? {7'd0, reg0} : (reg0 ? 8'd3 : 8'd2));
        end else if (is_ld) begin
            enc_ok      = (nregs == 2'd1) && has_num && num_ok;
            enc_op      = {7'b1001000, reg0};
            enc_has_arg = 1'b1;
        end else if (is_sj) begin
            enc_ok      = (nregs == 2'd0) && has_num && num_ok;
            enc_op      = base;
            enc_has_arg = 1'b1;
        end else if (is_halt) begin
            enc_ok = (nregs == 2'd0) && !has_num;
            enc_op = 8'hFF;
        end
    end

    always_comb begin
        state_n = state; mnem_n = mnem; mlen_n = mlen; nregs_n = nregs; reg0_n = reg0;
        in_tok_n = in_tok; val_n = val; ndig_n = ndig; num_sep_n = num_sep;
        arg_n = arg_q; has_arg_n = has_arg;
        we_n = 1'b0; wdata_n = mem_wdata; ok_n = 1'b0; err_n = 1'b0;
        finish = 1'b0; clear = 1'b0;
        case (state)
            S_MNEM: if (accept) begin
                if (is_letter) begin
                    if (mlen == 3'd4) state_n = S_ERR;
                    else begin
                        mnem_n = {mnem[23:0], ch};
                        mlen_n = mlen + 3'd1;
                    end
                end else if (is_space) begin
                    if (mlen != 3'd0) begin state_n = S_REG; in_tok_n = 1'b0; end
                end else if (is_eol) begin
                    finish = (mlen != 3'd0);
                end else state_n = S_ERR;
            end
            S_REG: if (accept) begin
                if (is_letter) begin
                    if (in_tok || nregs == 2'd2 || !(ch == 8'h41 || is_b) ||
                        (nregs == 2'd1 && reg0 == is_b)) state_n = S_ERR;
                    else begin
                        if (nregs == 2'd0) reg0_n = is_b;
                        nregs_n  = nregs + 2'd1;
                        in_tok_n = 1'b1;
                    end
                end else if (is_space) begin
                    in_tok_n = 1'b0;
                end else if (is_digit) begin
                    if (in_tok) state_n = S_ERR;
                    else begin
                        state_n = S_NUM; val_n = {6'd0, rx_data[3:0]};
                        ndig_n = 2'd1; num_sep_n = 1'b0;
                    end
                end else if (is_eol) finish = 1'b1;
                else state_n = S_ERR;
            end
            S_NUM: if (accept) begin
                if (is_digit) begin
                    if (num_sep || ndig == 2'd3) state_n = S_ERR;
                    else begin
                        val_n  = val * 10'd10 + {6'd0, rx_data[3:0]};
                        ndig_n = ndig + 2'd1;
                    end
                end else if (is_space) num_sep_n = 1'b1;
                else if (is_eol) finish = 1'b1;
                else state_n = S_ERR;
            end
            S_ERR: if (accept && is_eol) begin
                err_n = 1'b1; clear = 1'b1; state_n = S_MNEM;
            end
            S_EMIT_OP: begin
                if (has_arg) begin
                    we_n = 1'b1; wdata_n = arg_q; ok_n = 1'b1; state_n = S_EMIT_ARG;
                end else state_n = S_MNEM;
            end
            S_EMIT_ARG: state_n = S_MNEM;
            default:    state_n = S_MNEM;
        endcase
        if (finish) begin
            clear = 1'b1;
            if (enc_ok) begin
                we_n = 1'b1; wdata_n = enc_op; arg_n = val[7:0];
                has_arg_n = enc_has_arg; ok_n = !enc_has_arg; state_n = S_EMIT_OP;
            end else begin
                err_n = 1'b1; state_n = S_MNEM;
            end
        end
        if (clear) begin
            mnem_n = 32'd0; mlen_n = 3'd0; nregs_n = 2'd0; reg0_n = 1'b0;
            in_tok_n = 1'b0; val_n = 10'd0; ndig_n = 2'd0; num_sep_n = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset_btn) begin
            state <= S_MNEM; mnem <= 32'd0; mlen <= 3'd0; nregs <= 2'd0; reg0 <= 1'b0;
            in_tok <= 1'b0; val <= 10'd0; ndig <= 2'd0; num_sep <= 1'b0;
            arg_q <= 8'h00; has_arg <= 1'b0;
            mem_we <= 1'b0; mem_wdata <= 8'h00; line_ok <= 1'b0; line_err <= 1'b0;
            addr <= START_ADDR; wrap <= 1'b0;
        end else begin
            state <= state_n; mnem <= mnem_n; mlen <= mlen_n; nregs <= nregs_n; reg0 <= reg0_n;
            in_tok <= in_tok_n; val <= val_n; ndig <= ndig_n; num_sep <= num_sep_n;
            arg_q <= arg_n; has_arg <= has_arg_n;
            mem_we <= we_n; mem_wdata <= wdata_n; line_ok <= ok_n; line_err <= err_n;
            // Address post-increments after each written byte
            if (mem_we) begin
                addr <= addr + 8'd1;
                if (addr == 8'hFF) wrap <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire
